// File: rtl/mips32_mem_pkg.sv
// Shared types and constants for the MIPS32 memory responder and the core that talks to it.
package mips32_mem_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 12;
  localparam int DEPTH_DEF   = 1024;
  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mips32_mem_responder_if.sv
// Request/response handshake bundle between a memory requester (master) and the responder (slave).
interface mips32_mem_responder_if
  import mips32_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mips32_mem_array.sv
// Word storage with a synchronous read port and an arbitrated synchronous write path.
module mips32_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              ld_en,
  input  logic [IDX_W-1:0]  ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Commit write is issued after the load so it wins on a same-word collision;
  // the read samples the pre-edge contents.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mips32_mem_responder.sv
// Single-outstanding word memory responder with programmable wait states, range errors and a backdoor load port.
module mips32_mem_responder
  import mips32_mem_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mips32_mem_responder_if.slave  bus,
  output logic                   busy,
  input  logic                   load_en,
  input  logic [ADDR_W-1:0]      load_addr,
  input  logic [DATA_W-1:0]      load_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              rd_ok;

  logic              we_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;

  logic              accept;
  logic              commit;
  logic              c_we;
  logic              c_ok;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [DATA_W-1:0] arr_rdata;

  assign accept = (state == IDLE) && bus.req_valid && bus.req_ready;

  // With zero wait states the commit happens on the acceptance edge itself,
  // so the live request fields feed the array instead of the captured copy.
  always_comb begin
    c_we    = we_p0;
    c_addr  = addr_p0;
    c_wdata = wdata_p0;
    commit  = (state == WAIT) && (cnt == CNT_W'(1));
    if (LATENCY == 0) begin
      c_we    = bus.req_we;
      c_addr  = bus.req_addr;
      c_wdata = bus.req_wdata;
      commit  = accept;
    end
  end

  assign c_ok = in_range(c_addr);

  // ---- p0: request capture at acceptance ----
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= bus.req_we;
      addr_p0  <= bus.req_addr;
      wdata_p0 <= bus.req_wdata;
    end
  end

  mips32_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (commit && c_we && c_ok),
    .wr_addr (c_addr[IDX_W-1:0]),
    .wr_data (c_wdata),
    .ld_en   (load_en && in_range(load_addr)),
    .ld_addr (load_addr[IDX_W-1:0]),
    .ld_data (load_data),
    .rd_en   (commit && !c_we && c_ok),
    .rd_addr (c_addr[IDX_W-1:0]),
    .rd_data (arr_rdata)
  );

  // ---- p1: transaction control; response flags register on the commit edge ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      bus.req_ready  <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      rd_ok          <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            bus.req_ready <= 1'b0;
            busy          <= 1'b1;
            if (LATENCY == 0) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= !c_ok;
              rd_ok          <= c_ok && !c_we;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(LATENCY);
            end
          end else begin
            bus.req_ready <= 1'b1;
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= !c_ok;
            rd_ok          <= c_ok && !c_we;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            rd_ok          <= 1'b0;
            busy           <= 1'b0;
            bus.req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data is only exposed for successful reads; writes and errors return zero.
  assign bus.resp_rdata = rd_ok ? arr_rdata : '0;

endmodule

// File: tb/tb_mips32_mem_responder.sv
// Bench for mips32_mem_responder: three builds (LATENCY 0, 1, 15) driven from vector tables, hand sequences and random traffic.
module tb_mips32_mem_responder;

  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int DEPTH = 1024;
  localparam int LAT [3] = '{0, 1, 15};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          rq_valid [3];
  logic          rq_we    [3];
  logic [AW-1:0] rq_addr  [3];
  logic [DW-1:0] rq_wdata [3];
  logic          rs_ready [3];
  logic          rq_ready [3];
  logic          rs_valid [3];
  logic          rs_err   [3];
  logic [DW-1:0] rs_rdata [3];
  logic          bsy      [3];
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] mdl [3][DEPTH];

  mips32_mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus [3] ();

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      assign bus[g].req_valid  = rq_valid[g];
      assign bus[g].req_we     = rq_we[g];
      assign bus[g].req_addr   = rq_addr[g];
      assign bus[g].req_wdata  = rq_wdata[g];
      assign bus[g].resp_ready = rs_ready[g];
      assign rq_ready[g] = bus[g].req_ready;
      assign rs_valid[g] = bus[g].resp_valid;
      assign rs_err[g]   = bus[g].resp_err;
      assign rs_rdata[g] = bus[g].resp_rdata;

      mips32_mem_responder #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (DEPTH),
        .LATENCY(LAT[g])
      ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus[g]),
        .busy     (bsy[g]),
        .load_en  (load_en),
        .load_addr(load_addr),
        .load_data(load_data)
      );
    end
  endgenerate

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            hold;
    logic [DW-1:0] exp_rd;
    logic          exp_err;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic ld_word(input logic [AW-1:0] a, input logic [DW-1:0] v);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = v;
    @(posedge clk); #1;
    load_en = 1'b0;
    if (int'(a) < DEPTH)
      for (int k = 0; k < 3; k++) mdl[k][a[9:0]] = v;
  endtask

  task automatic wait_ready(input int d);
    int gd;
    gd = 0;
    @(negedge clk);
    while (!rq_ready[d] && gd < 50) begin @(negedge clk); gd++; end
    if (!rq_ready[d]) chk1("req_ready_wait", rq_ready[d], 1'b1);
  endtask

  // One full transaction: accept, measure accept-to-valid spacing, optional backpressure, handshake.
  task automatic txn(input int d, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                     input int hold, input logic le, input logic [DW-1:0] ld,
                     output logic [DW-1:0] rd, output logic er, output int lat);
    wait_ready(d);
    rq_valid[d] = 1'b1; rq_we[d] = we; rq_addr[d] = addr; rq_wdata[d] = wd;
    if (le) begin load_en = 1'b1; load_addr = addr; load_data = ld; end
    @(posedge clk); #1;
    rq_valid[d] = 1'b0; load_en = 1'b0;
    rq_we[d] = 1'($urandom); rq_addr[d] = AW'($urandom); rq_wdata[d] = $urandom;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rs_valid[d] && lat < 40);
    rd = rs_rdata[d];
    er = rs_err[d];
    if (hold > 0) rq_valid[d] = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk1("bp_valid", rs_valid[d], 1'b1);
      chk("bp_rdata", rs_rdata[d], rd);
      chk1("bp_err", rs_err[d], er);
      chk1("bp_req_ready", rq_ready[d], 1'b0);
      chk1("bp_busy", bsy[d], 1'b1);
    end
    rq_valid[d] = 1'b0;
    rs_ready[d] = 1'b1;
    @(posedge clk); #1;
    rs_ready[d] = 1'b0;
    @(negedge clk);
    chk1("post_hs_req_ready", rq_ready[d], 1'b1);
    chk1("post_hs_valid", rs_valid[d], 1'b0);
  endtask

  // Transaction checked against the reference memory model.
  task automatic run(input int d, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                     input int hold, input logic le, input logic [DW-1:0] ld);
    logic [DW-1:0] rd, erd;
    logic er;
    int lat;
    bit ok;
    ok = int'(addr) < DEPTH;
    if (le && ok && LAT[d] > 0)
      for (int k = 0; k < 3; k++) mdl[k][addr[9:0]] = ld;
    erd = (!we && ok) ? mdl[d][addr[9:0]] : '0;
    txn(d, we, addr, wd, hold, le, ld, rd, er, lat);
    chk("run_latency", 32'(lat), 32'(LAT[d] + 1));
    chk("run_rdata", rd, erd);
    chk1("run_err", er, !ok);
    if (le && ok && LAT[d] == 0)
      for (int k = 0; k < 3; k++) mdl[k][addr[9:0]] = ld;
    if (we && ok) mdl[d][addr[9:0]] = wd;
  endtask

  // Back-to-back reads with resp_ready high: acceptances must be LATENCY+2 apart.
  task automatic period(input int d);
    int prev, nacc, gd;
    wait_ready(d);
    rq_valid[d] = 1'b1; rq_we[d] = 1'b0; rq_addr[d] = 12'd3; rs_ready[d] = 1'b1;
    prev = -1; nacc = 0;
    for (int c = 0; c < 4 * (LAT[d] + 2); c++) begin
      if (rq_ready[d]) begin
        if (prev >= 0) chk("period", 32'(c - prev), 32'(LAT[d] + 2));
        prev = c;
        nacc++;
      end
      @(negedge clk);
    end
    rq_valid[d] = 1'b0;
    chk1("period_accepts", nacc >= 3, 1'b1);
    gd = 0;
    while (bsy[d] && gd < 40) begin @(negedge clk); gd++; end
    chk1("period_drain", bsy[d], 1'b0);
    rs_ready[d] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rd;
    logic er;
    int lat, d, gd;
    logic we;
    logic [AW-1:0] a;

    for (int k = 0; k < 3; k++) begin
      rq_valid[k] = 1'b0; rq_we[k] = 1'b0; rq_addr[k] = '0; rq_wdata[k] = '0; rs_ready[k] = 1'b0;
    end
    load_en = 1'b0; load_addr = '0; load_data = '0;

    tbl[0] = '{we:1'b0, addr:12'd0,    wdata:32'h0,        hold:0, exp_rd:32'h2801000a, exp_err:1'b0};
    tbl[1] = '{we:1'b1, addr:12'd5,    wdata:32'h0000001e, hold:0, exp_rd:32'h0,        exp_err:1'b0};
    tbl[2] = '{we:1'b0, addr:12'd5,    wdata:32'h0,        hold:0, exp_rd:32'h0000001e, exp_err:1'b0};
    tbl[3] = '{we:1'b0, addr:12'd1024, wdata:32'h0,        hold:2, exp_rd:32'h0,        exp_err:1'b1};
    tbl[4] = '{we:1'b1, addr:12'd1024, wdata:32'hdeadbeef, hold:0, exp_rd:32'h0,        exp_err:1'b1};
    tbl[5] = '{we:1'b0, addr:12'd0,    wdata:32'h0,        hold:6, exp_rd:32'h2801000a, exp_err:1'b0};
    tbl[6] = '{we:1'b1, addr:12'd4095, wdata:32'h12345678, hold:0, exp_rd:32'h0,        exp_err:1'b1};
    tbl[7] = '{we:1'b0, addr:12'd1023, wdata:32'h0,        hold:0, exp_rd:32'ha5a50001, exp_err:1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk1("rst_req_ready", rq_ready[k], 1'b0);
      chk1("rst_resp_valid", rs_valid[k], 1'b0);
      chk1("rst_resp_err", rs_err[k], 1'b0);
      chk1("rst_busy", bsy[k], 1'b0);
      chk("rst_rdata", rs_rdata[k], 32'h0);
    end
    rst_n = 1'b1;
    #1 chk1("rel_ready_low", rq_ready[1], 1'b0);
    @(negedge clk);
    chk1("rel_ready_high", rq_ready[1], 1'b1);

    for (int i = 0; i < DEPTH; i++) ld_word(AW'(i), $urandom);
    ld_word(12'd0, 32'h2801000a);
    ld_word(12'd1023, 32'ha5a50001);

    // Directed vectors on the LATENCY=1 build
    for (int i = 0; i < 8; i++) begin
      txn(1, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].hold, 1'b0, 32'h0, rd, er, lat);
      chk("tbl_rdata", rd, tbl[i].exp_rd);
      chk1("tbl_err", er, tbl[i].exp_err);
      chk("tbl_latency", 32'(lat), 32'd2);
      if (tbl[i].we && int'(tbl[i].addr) < DEPTH) mdl[1][tbl[i].addr[9:0]] = tbl[i].wdata;
    end

    // Out-of-range backdoor load must not alias onto word 0
    ld_word(12'd1024, 32'hbad0bad0);
    run(1, 1'b0, 12'd0, 32'h0, 0, 1'b0, 32'h0);

    // Same-edge load collisions on the zero-wait build
    run(0, 1'b1, 12'd9, 32'h12345678, 0, 1'b1, 32'h99999999);
    run(0, 1'b0, 12'd9, 32'h0, 0, 1'b0, 32'h0);
    run(1, 1'b0, 12'd9, 32'h0, 0, 1'b0, 32'h0);
    run(0, 1'b0, 12'd9, 32'h0, 0, 1'b1, 32'h55555555);
    run(0, 1'b0, 12'd9, 32'h0, 0, 1'b0, 32'h0);

    for (int k = 0; k < 3; k++) period(k);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      d  = $urandom_range(0, 2);
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = AW'($urandom_range(1024, 4095));
      else if ($urandom_range(0, 1) == 0) a = AW'($urandom_range(0, 31));
      else a = AW'($urandom_range(0, 1023));
      run(d, we, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 5) == 0, $urandom);
    end

    // Reset in the middle of a LATENCY=15 write wait
    ld_word(12'd7, 32'h00000011);
    wait_ready(2);
    rq_valid[2] = 1'b1; rq_we[2] = 1'b1; rq_addr[2] = 12'd7; rq_wdata[2] = 32'hcafef00d;
    @(posedge clk); #1;
    rq_valid[2] = 1'b0;
    repeat (4) @(negedge clk);
    chk1("wait_busy", bsy[2], 1'b1);
    chk1("wait_no_valid", rs_valid[2], 1'b0);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk1("abort_req_ready", rq_ready[k], 1'b0);
      chk1("abort_resp_valid", rs_valid[k], 1'b0);
      chk1("abort_resp_err", rs_err[k], 1'b0);
      chk1("abort_busy", bsy[k], 1'b0);
      chk("abort_rdata", rs_rdata[k], 32'h0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk1("abort_rel_ready_low", rq_ready[2], 1'b0);
    gd = 0;
    @(negedge clk);
    chk1("abort_rel_ready_high", rq_ready[2], 1'b1);
    run(2, 1'b0, 12'd7, 32'h0, 0, 1'b0, 32'h0);
    chk("abort_mem7", mdl[2][7], 32'h00000011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
